// File: rtl/net_recv_frame_buffer.sv
// Store-and-forward ingress frame buffer: only whole, error-free, correctly sized frames
// are released to the NET_RECV_0 AXIS input; bad frames are rewound in place.
module net_recv_frame_buffer #(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned KEEP_WIDTH      = 64,
  parameter int unsigned DEPTH           = 64,
  parameter int unsigned MIN_FRAME_BYTES = 60,
  parameter int unsigned MAX_FRAME_BEATS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           frame_count,
  output logic [31:0]           drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int unsigned BW = $clog2(MAX_FRAME_BEATS + 2);

  typedef enum logic [1:0] {StIdle, StRecv, StDrop} wr_state_e;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   rd_data_q;
  logic            rd_valid_q;

  wr_state_e       wr_state_q;
  logic [PW-1:0]   wr_cur_q;
  logic [PW-1:0]   wr_commit_q;
  logic [PW-1:0]   rd_q;
  logic [15:0]     byte_cnt_q;
  logic [BW-1:0]   beat_cnt_q;
  logic [31:0]     frame_count_q;
  logic [31:0]     drop_count_q;

  logic [DATA_WIDTH-1:0] out_data_q;
  logic [KEEP_WIDTH-1:0] out_keep_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  logic            beat_acc;
  logic            full;
  logic            empty;
  logic            receiving;
  logic            mem_we;
  logic            too_long;
  logic            to_drop;
  logic            frame_good;
  logic [15:0]     keep_bytes;
  logic [16:0]     byte_sum;
  logic [15:0]     byte_cnt_inc;
  logic [BW-1:0]   beat_cnt_inc;
  logic [PW-1:0]   wr_cur_inc;
  logic            out_load;
  logic            rd_en;

  assign s_axis_tready = ~rst;
  assign beat_acc      = s_axis_tvalid & s_axis_tready;

  // Occupancy is measured against rd, so uncommitted beats also consume space.
  assign full      = (wr_cur_q - rd_q) == PW'(DEPTH);
  assign empty     = (rd_q == wr_commit_q);
  assign receiving = (wr_state_q != StDrop);
  assign mem_we    = beat_acc & receiving & ~full;
  assign wr_cur_inc = wr_cur_q + PW'(1);

  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_bytes = keep_bytes + {15'd0, s_axis_tkeep[i]};
    end
  end

  assign byte_sum     = {1'b0, byte_cnt_q} + {1'b0, keep_bytes};
  assign byte_cnt_inc = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  assign beat_cnt_inc = beat_cnt_q + BW'(1);
  assign too_long     = beat_cnt_inc > BW'(MAX_FRAME_BEATS);
  assign to_drop      = full | too_long;
  assign frame_good   = ~s_axis_tuser & (byte_cnt_inc >= 16'(MIN_FRAME_BYTES)) & ~to_drop;

  // Write-side FSM: speculative writes at wr_cur, committed or rewound on tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q    <= StIdle;
      wr_cur_q      <= '0;
      wr_commit_q   <= '0;
      byte_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else if (beat_acc) begin
      if (!receiving) begin
        if (s_axis_tlast) begin
          wr_cur_q     <= wr_commit_q;
          drop_count_q <= drop_count_q + 32'd1;
          byte_cnt_q   <= '0;
          beat_cnt_q   <= '0;
          wr_state_q   <= StIdle;
        end
      end else if (s_axis_tlast) begin
        byte_cnt_q <= '0;
        beat_cnt_q <= '0;
        wr_state_q <= StIdle;
        if (frame_good) begin
          wr_cur_q      <= wr_cur_inc;
          wr_commit_q   <= wr_cur_inc;
          frame_count_q <= frame_count_q + 32'd1;
        end else begin
          wr_cur_q     <= wr_commit_q;
          drop_count_q <= drop_count_q + 32'd1;
        end
      end else begin
        if (!full) begin
          wr_cur_q <= wr_cur_inc;
        end
        byte_cnt_q <= byte_cnt_inc;
        beat_cnt_q <= beat_cnt_inc;
        wr_state_q <= to_drop ? StDrop : StRecv;
      end
    end
  end

  // A read is only issued when the read stage will drain into the output register
  // in the same cycle, so the read stage never needs its own stall path.
  assign out_load = ~out_valid_q | m_axis_tready;
  assign rd_en    = ~empty & out_load;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cur_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= '0;
      rd_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd_q <= rd_q + PW'(1);
      end
      if (out_load) begin
        rd_valid_q  <= rd_en;
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) begin
          {out_last_q, out_keep_q, out_data_q} <= rd_data_q;
        end
      end
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  assign frame_count   = frame_count_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_net_recv_frame_buffer.sv
// Scoreboard bench for net_recv_frame_buffer: the driver queues expected beats of frames
// it knows to be good; a monitor pops and compares every m_axis transfer.
module tb_net_recv_frame_buffer;

  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [31:0]   frame_count;
  logic [31:0]   drop_count;

  int    total = 0;
  int    bad = 0;
  int    popped = 0;
  int    exp_frames = 0;
  int    exp_drops = 0;
  bit    rand_ready = 1'b0;
  bit    ready_fixed = 1'b1;
  beat_t exp_q[$];

  net_recv_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each transfer and checks stability while stalled.
  initial begin
    beat_t held;
    beat_t got;
    beat_t e;
    bit    stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = '{last: m_tlast, keep: m_tkeep, data: m_tdata};
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          total++;
          if (!m_tvalid || got !== held) begin
            bad++;
            $display("FAIL stall_stable: got v=%b %h expected v=1 %h", m_tvalid, got, held);
          end
        end
        if (m_tvalid && m_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_beat: got %h expected no output", got);
          end else begin
            e = exp_q.pop_front();
            popped++;
            if (got !== e) begin
              bad++;
              $display("FAIL beat: got %h expected %h", got, e);
            end
          end
          stalled = 1'b0;
        end else if (m_tvalid) begin
          stalled = 1'b1;
          held = got;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Caller is at posedge+1; returns at the posedge+1 after the beat was taken.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic u);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [KW-1:0] keep_of(input int n);
    logic [KW:0] t;
    t = ({{KW{1'b0}}, 1'b1} << n) - 1'b1;
    return t[KW-1:0];
  endfunction

  task automatic send_frame(input int nbeats, input int last_bytes, input logic user,
                            input bit good);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    for (int b = 0; b < nbeats; b++) begin
      d = rand_data();
      l = (b == nbeats - 1);
      k = l ? keep_of(last_bytes) : {KW{1'b1}};
      if (good) exp_q.push_back('{last: l, keep: k, data: d});
      send_beat(d, k, l, l ? user : 1'b0);
    end
    if (good) exp_frames++;
    else exp_drops++;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    check32(name, exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string name);
    check32({name, "_frames"}, frame_count, exp_frames);
    check32({name, "_drops"}, drop_count, exp_drops);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_tvalid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check32("rst_tready", s_tready, 0);
    check32("rst_tvalid", m_tvalid, 0);
    rst = 1'b0;
    exp_frames = 0;
    exp_drops = 0;
    #1;
    check32("post_rst_tready", s_tready, 1);
    check_counts("post_rst");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int lb;
    int guard;
    int pop0;

    // T1: 2-beat 128 B frame, check 2-cycle latency
    ready_fixed = 1'b1;
    reset_dut();
    send_frame(2, 64, 1'b0, 1'b1);
    check32("t1_lat0", m_tvalid, 0);
    @(posedge clk); #1;
    check32("t1_lat1", m_tvalid, 0);
    @(posedge clk); #1;
    check32("t1_lat2", m_tvalid, 1);
    wait_drain("t1_drain", 50);
    check_counts("t1");

    // T2: 40 B runt
    reset_dut();
    send_frame(1, 40, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check32("t2_no_out", m_tvalid, 0);
    check_counts("t2");

    // T3: errored frame then good 64 B frame
    reset_dut();
    send_frame(3, 64, 1'b1, 1'b0);
    send_frame(1, 64, 1'b0, 1'b1);
    wait_drain("t3_drain", 50);
    check_counts("t3");

    // T4: oversize, fill, overflow, drain
    ready_fixed = 1'b0;
    reset_dut();
    send_frame(33, 64, 1'b0, 1'b0);
    send_frame(32, 64, 1'b0, 1'b1);
    send_frame(32, 64, 1'b0, 1'b1);
    send_frame(32, 64, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_counts("t4_full");
    check32("t4_held_valid", m_tvalid, 1);
    pop0 = popped;
    ready_fixed = 1'b1;
    wait_drain("t4_drain", 200);
    check32("t4_beats_out", popped - pop0, 64);
    send_frame(32, 64, 1'b0, 1'b1);
    wait_drain("t4_drain2", 200);
    check_counts("t4_end");

    // T5: random frames with random backpressure; throttle so the buffer never fills
    reset_dut();
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 32);
      lb = (n == 1) ? $urandom_range(60, 64) : $urandom_range(1, 64);
      guard = 0;
      while (exp_q.size() + n > DEPTH && guard < 2000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      send_frame(n, lb, 1'b0, 1'b1);
    end
    wait_drain("t5_drain", 3000);
    rand_ready = 1'b0;
    ready_fixed = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_counts("t5");

    // T6: reset during beat 3 of 5 while output is active
    reset_dut();
    send_frame(3, 64, 1'b0, 1'b1);
    send_beat(rand_data(), {KW{1'b1}}, 1'b0, 1'b0);
    send_beat(rand_data(), {KW{1'b1}}, 1'b0, 1'b0);
    s_tdata  = rand_data();
    s_tkeep  = {KW{1'b1}};
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    check32("t6_out_active", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check32("t6_rst_tvalid", m_tvalid, 0);
    check32("t6_rst_frames", frame_count, 0);
    check32("t6_rst_drops", drop_count, 0);
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_drops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(2, 64, 1'b0, 1'b1);
    wait_drain("t6_drain", 50);
    check_counts("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
